// File: rtl/multi_slave_arbiter_if.sv
// Signal bundle between the slave channels, the arbiter and the downstream master port.
interface multi_slave_arbiter_if #(
    parameter int NCH = 4,
    parameter int DW  = 32
);
    localparam int CW = $clog2(NCH);

    logic [2*NCH-1:0]  slv_mode;
    logic [NCH-1:0]    slv_data_valid;
    logic [8*NCH-1:0]  slv_proc_valid;
    logic [DW*NCH-1:0] slv_data;
    logic [NCH-1:0]    slv_ready;

    logic [DW-1:0]     mstr0_data;
    logic [1:0]        mstr0_mode;
    logic [CW-1:0]     mstr0_src;
    logic              mstr0_last;
    logic              mstr0_data_valid;
    logic              mstr0_ready;

    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_threshold;
    logic              mstr0_cmplt;
    logic              burst_err;

    // master: the arbiter itself, driving readies, the head word and status
    modport master (
        input  slv_mode, slv_data_valid, slv_proc_valid, slv_data, mstr0_ready,
        output slv_ready, mstr0_data, mstr0_mode, mstr0_src, mstr0_last,
        output mstr0_data_valid, fifo_full, fifo_empty, fifo_threshold,
        output mstr0_cmplt, burst_err
    );

    modport slave (
        output slv_mode, slv_data_valid, slv_proc_valid, slv_data, mstr0_ready,
        input  slv_ready, mstr0_data, mstr0_mode, mstr0_src, mstr0_last,
        input  mstr0_data_valid, fifo_full, fifo_empty, fifo_threshold,
        input  mstr0_cmplt, burst_err
    );
endinterface

// File: rtl/multi_slave_arbiter.sv
// Round-robin burst arbiter: grants one slave channel at a time and streams its
// words into a first-word-fall-through FIFO feeding the single master port.
module multi_slave_arbiter #(
    parameter int NCH    = 4,
    parameter int DW     = 32,
    parameter int DEPTH  = 16,
    parameter int AF_LVL = DEPTH - 4,
    parameter int TMO    = 64
) (
    input  logic clk,
    input  logic rst,
    multi_slave_arbiter_if.master bus
);
    localparam int CW = $clog2(NCH);
    localparam int AW = $clog2(DEPTH);
    localparam int NW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(TMO + 1);

    typedef enum logic {IDLE, BURST} state_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [1:0]    mode;
        logic [CW-1:0] src;
        logic          last;
    } entry_t;

    state_t        state, state_nxt;
    logic [CW-1:0] rr_ptr, gch, grant_ch;
    logic [1:0]    gmode;
    logic [7:0]    bcnt;
    logic [TW-1:0] tmo_cnt;
    logic          grant_vld, acc, done, abort, idle_cyc;
    logic [CW:0]   idx;
    logic [NCH-1:0] req, ready;

    logic [DW-1:0] ch_data [NCH];
    logic [1:0]    ch_mode [NCH];
    logic [7:0]    ch_len  [NCH];

    entry_t        mem [DEPTH];
    entry_t        head;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [NW-1:0] count, count_nxt;
    logic          full, empty, thr, push, pop;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        assign ch_data[i] = bus.slv_data[i*DW +: DW];
        assign ch_mode[i] = bus.slv_mode[2*i +: 2];
        assign ch_len[i]  = bus.slv_proc_valid[8*i +: 8];
        assign req[i]     = bus.slv_data_valid[i] && (ch_len[i] != 8'd0);
    end

    // Rotating-priority scan starting at rr_ptr, wrapping modulo NCH
    always_comb begin
        grant_vld = 1'b0;
        grant_ch  = '0;
        idx       = '0;
        for (int k = 0; k < NCH; k++) begin
            idx = {1'b0, rr_ptr} + (CW+1)'(k);
            if (idx >= (CW+1)'(NCH)) idx = idx - (CW+1)'(NCH);
            if (!grant_vld && req[idx[CW-1:0]]) begin
                grant_vld = 1'b1;
                grant_ch  = idx[CW-1:0];
            end
        end
    end

    always_comb begin
        ready = '0;
        if (state == BURST && !full && !rst) ready[gch] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        acc       = 1'b0;
        done      = 1'b0;
        abort     = 1'b0;
        idle_cyc  = 1'b0;
        case (state)
            IDLE: if (grant_vld && !rst) state_nxt = BURST;
            BURST: begin
                acc      = ready[gch] && bus.slv_data_valid[gch];
                idle_cyc = !acc && !full && !rst;
                if (acc && bcnt == 8'd1) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end else if (idle_cyc && tmo_cnt == TW'(TMO - 1)) begin
                    // stalled too long: drop the burst, keep what was written
                    abort     = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr  <= '0;
            gch     <= '0;
            gmode   <= '0;
            bcnt    <= '0;
            tmo_cnt <= '0;
        end else begin
            if (state == IDLE && grant_vld) begin
                gch     <= grant_ch;
                gmode   <= ch_mode[grant_ch];
                bcnt    <= ch_len[grant_ch];
                tmo_cnt <= '0;
            end
            if (acc) begin
                bcnt    <= bcnt - 8'd1;
                tmo_cnt <= '0;
            end else if (idle_cyc) begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end
            if (done || abort)
                rr_ptr <= (gch == CW'(NCH - 1)) ? '0 : gch + CW'(1);
        end
    end

    assign push = acc;
    assign pop  = !empty && bus.mstr0_ready;

    always_comb begin
        case ({push, pop})
            2'b10:   count_nxt = count + NW'(1);
            2'b01:   count_nxt = count - NW'(1);
            default: count_nxt = count;
        endcase
    end

    // Status flags registered alongside count so they always match it
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
            thr    <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_nxt;
            full  <= (count_nxt == NW'(DEPTH));
            empty <= (count_nxt == '0);
            thr   <= (count_nxt >= NW'(AF_LVL));
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{data: ch_data[gch], mode: gmode, src: gch, last: (bcnt == 8'd1)};
    end

    assign head = empty ? '0 : mem[rd_ptr];

    assign bus.slv_ready        = ready;
    assign bus.mstr0_data       = head.data;
    assign bus.mstr0_mode       = head.mode;
    assign bus.mstr0_src        = head.src;
    assign bus.mstr0_last       = head.last;
    assign bus.mstr0_data_valid = !empty;
    assign bus.fifo_full        = full;
    assign bus.fifo_empty       = empty;
    assign bus.fifo_threshold   = thr;
    assign bus.mstr0_cmplt      = done;
    assign bus.burst_err        = abort;
endmodule
